data_line_sequencer: RTL and testbench

Command-driven controller that sequences the data-cell datapath (RAM plus loadable up/down data counter) for Brainfuck-style cell operations. It accepts one run-length-encoded command at a time (`+`×N, `-`×N, `[-]` clear, zero-test). It emits the LOAD, INC/DEC and STORE strobes in the required order, tracks the cell value in a shadow register, and reports the cell's zero status for loop decisions. It sits between the instruction decoder and the data-line datapath and owns those strobes exclusively.

---
 rtl/data_line_sequencer.sv | 175 +++++++++++++++++
 tb/tb_data_line_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_line_sequencer.sv
// data_line_sequencer: LOAD/STEP/STORE strobe sequencer for one data cell.
// Optional DL_SEQ_FOLD_EN folds INC/DEC counts modulo 2^DATA_WIDTH.
module data_line_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 12
) (
    input  logic                   CLOCK,
    input  logic                   RST,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [1:0]             CMD_OP,
    input  logic [COUNT_WIDTH-1:0] CMD_COUNT,
    input  logic [DATA_WIDTH-1:0]  CELL_DATA,
    output logic                   LOAD,
    output logic                   INC,
    output logic                   DEC,
    output logic                   STORE,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   ZERO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_STORE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_INC  = 2'd0;
    localparam logic [1:0] OP_DEC  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] OP_TEST = 2'd3;

    localparam logic [DATA_WIDTH-1:0]  DATA_ONE = 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = 1;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic                   zero_q, zero_d;
    logic                   load_q, load_d;
    logic                   inc_q, inc_d;
    logic                   dec_q, dec_d;
    logic                   store_q, store_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;

    logic                   accept;
    logic [COUNT_WIDTH-1:0] eff_count;

    assign accept = CMD_VALID & ready_q;

`ifdef DL_SEQ_FOLD_EN
    localparam logic [COUNT_WIDTH-1:0] FOLD_MASK =
        COUNT_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);
    assign eff_count = CMD_COUNT & FOLD_MASK;
`else
    assign eff_count = CMD_COUNT;
`endif

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            op_q        <= OP_INC;
            remaining_q <= '0;
            shadow_q    <= '0;
            zero_q      <= 1'b0;
            load_q      <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            store_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            shadow_q    <= shadow_d;
            zero_q      <= zero_d;
            load_q      <= load_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            store_q     <= store_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        shadow_d    = shadow_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_LOAD;
                    op_d        = CMD_OP;
                    remaining_d = CMD_OP[1] ? '0 : eff_count;
                end
            end
            S_LOAD: begin
                shadow_d = CELL_DATA;
                unique case (op_q)
                    OP_INC, OP_DEC: begin
                        if (remaining_q != '0) begin
                            state_d = S_STEP;
                        end else begin
`ifdef DL_SEQ_FOLD_EN
                            state_d = S_DONE;
`else
                            state_d = S_STORE;
`endif
                        end
                    end
                    OP_CLR:  state_d = (CELL_DATA != '0) ? S_STEP : S_STORE;
                    OP_TEST: state_d = S_DONE;
                    default: state_d = S_IDLE;
                endcase
            end
            S_STEP: begin
                if (op_q == OP_INC) begin
                    shadow_d = shadow_q + DATA_ONE;
                end else begin
                    shadow_d = shadow_q - DATA_ONE;
                end
                // CLEAR runs until the shadow hits zero; INC/DEC use the count
                if (op_q == OP_CLR) begin
                    if (shadow_q == DATA_ONE) begin
                        state_d = S_STORE;
                    end
                end else begin
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = S_STORE;
                    end
                end
            end
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop
    always_comb begin
        load_d  = (state_d == S_LOAD);
        inc_d   = (state_d == S_STEP) && (op_d == OP_INC);
        dec_d   = (state_d == S_STEP) && (op_d != OP_INC);
        store_d = (state_d == S_STORE);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        zero_d  = zero_q;
        if (state_d == S_DONE) begin
            zero_d = (shadow_d == '0);
        end
    end

    assign LOAD      = load_q;
    assign INC       = inc_q;
    assign DEC       = dec_q;
    assign STORE     = store_q;
    assign DONE      = done_q;
    assign BUSY      = busy_q;
    assign CMD_READY = ready_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_data_line_sequencer.sv
// tb_data_line_sequencer: directed checks of data_line_sequencer with a
// small RAM-cell plus counter model driven by the DUT strobes.
module tb_data_line_sequencer;

    logic        CLOCK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'd0;
    logic [11:0] CMD_COUNT = 12'd0;
    logic [7:0]  CELL_DATA;
    logic        LOAD, INC, DEC, STORE, BUSY, DONE, ZERO;

    localparam logic [1:0] OP_INC  = 2'd0;
    localparam logic [1:0] OP_DEC  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] OP_TEST = 2'd3;

    logic [7:0] cell_m = 8'h00;
    logic [7:0] cnt_m = 8'h00;
    logic [7:0] last_store = 8'h00;
    int n_load = 0, n_inc = 0, n_dec = 0, n_store = 0, n_ovl = 0;

    int   tests = 0;
    int   failed = 0;
    int   lat;
    int   d_load, d_inc, d_dec, d_store, d_ovl;
    logic z_done;

    data_line_sequencer #(
        .DATA_WIDTH (8),
        .COUNT_WIDTH(12)
    ) dut (
        .CLOCK    (CLOCK),
        .RST      (RST),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_OP   (CMD_OP),
        .CMD_COUNT(CMD_COUNT),
        .CELL_DATA(CELL_DATA),
        .LOAD     (LOAD),
        .INC      (INC),
        .DEC      (DEC),
        .STORE    (STORE),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ZERO     (ZERO)
    );

    always #5 CLOCK = ~CLOCK;

    assign CELL_DATA = cell_m;

    // Datapath model: strobes are sampled mid-cycle
    always @(negedge CLOCK) begin
        if ($countones({LOAD, INC, DEC, STORE, DONE}) > 1) n_ovl++;
        if (LOAD) begin
            n_load++;
            cnt_m <= CELL_DATA;
        end
        if (INC) begin
            n_inc++;
            cnt_m <= cnt_m + 8'd1;
        end
        if (DEC) begin
            n_dec++;
            cnt_m <= cnt_m - 8'd1;
        end
        if (STORE) begin
            n_store++;
            last_store <= cnt_m;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [11:0] n);
        int s_load, s_inc, s_dec, s_store, s_ovl;
        @(posedge CLOCK);
        #1;
        s_load = n_load;
        s_inc = n_inc;
        s_dec = n_dec;
        s_store = n_store;
        s_ovl = n_ovl;
        CMD_OP = op;
        CMD_COUNT = n;
        CMD_VALID = 1'b1;
        @(posedge CLOCK);
        #1;
        CMD_VALID = 1'b0;
        lat = -1;
        z_done = 1'bx;
        for (int c = 1; c <= 400; c++) begin
            if (DONE) begin
                lat = c;
                z_done = ZERO;
                break;
            end
            @(posedge CLOCK);
            #1;
        end
        d_load = n_load - s_load;
        d_inc = n_inc - s_inc;
        d_dec = n_dec - s_dec;
        d_store = n_store - s_store;
        d_ovl = n_ovl - s_ovl;
        if (d_store > 0) cell_m = last_store;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #3;
        RST = 1'b0;
        #10;
        tests++;
        if ({CMD_READY, BUSY, LOAD, INC, DEC, STORE, DONE, ZERO} !== 8'b1000_0000) begin
            failed++;
            $display("FAIL reset_outputs got %b want %b",
                     {CMD_READY, BUSY, LOAD, INC, DEC, STORE, DONE, ZERO}, 8'b1000_0000);
        end
        @(negedge CLOCK);
        RST = 1'b1;
        @(posedge CLOCK);
        #1;
        tests++;
        if ({CMD_READY, BUSY} !== 2'b10) begin
            failed++;
            $display("FAIL reset_idle got %b want 10", {CMD_READY, BUSY});
        end
    endtask

    task automatic test_inc();
        cell_m = 8'h05;
        issue(OP_INC, 12'd3);
        tests++;
        if (lat !== 6) begin failed++; $display("FAIL inc3_latency got %0d want 6", lat); end
        tests++;
        if (d_load !== 1) begin failed++; $display("FAIL inc3_load got %0d want 1", d_load); end
        tests++;
        if (d_inc !== 3 || d_dec !== 0) begin
            failed++;
            $display("FAIL inc3_pulses got inc=%0d dec=%0d want 3/0", d_inc, d_dec);
        end
        tests++;
        if (d_store !== 1) begin failed++; $display("FAIL inc3_store got %0d want 1", d_store); end
        tests++;
        if (z_done !== 1'b0) begin failed++; $display("FAIL inc3_zero got %b want 0", z_done); end
        tests++;
        if (cell_m !== 8'h08) begin failed++; $display("FAIL inc3_cell got %h want 08", cell_m); end
        tests++;
        if (d_ovl !== 0) begin failed++; $display("FAIL inc3_overlap got %0d want 0", d_ovl); end
    endtask

    task automatic test_back_to_back();
        cell_m = 8'h10;
        issue(OP_INC, 12'd1);
        tests++;
        if ({CMD_READY, BUSY} !== 2'b01) begin
            failed++;
            $display("FAIL b2b_done_cycle got %b want 01", {CMD_READY, BUSY});
        end
        @(posedge CLOCK);
        #1;
        tests++;
        if ({CMD_READY, BUSY, DONE} !== 3'b100) begin
            failed++;
            $display("FAIL b2b_ready_after got %b want 100", {CMD_READY, BUSY, DONE});
        end
        tests++;
        if (cell_m !== 8'h11) begin failed++; $display("FAIL b2b_cell got %h want 11", cell_m); end
    endtask

    task automatic test_dec_and_test();
        cell_m = 8'h01;
        issue(OP_DEC, 12'd1);
        tests++;
        if (lat !== 4) begin failed++; $display("FAIL dec1_latency got %0d want 4", lat); end
        tests++;
        if (d_dec !== 1 || d_inc !== 0) begin
            failed++;
            $display("FAIL dec1_pulses got dec=%0d inc=%0d want 1/0", d_dec, d_inc);
        end
        tests++;
        if (z_done !== 1'b1) begin failed++; $display("FAIL dec1_zero got %b want 1", z_done); end
        tests++;
        if (cell_m !== 8'h00) begin failed++; $display("FAIL dec1_cell got %h want 00", cell_m); end
        issue(OP_TEST, 12'd9);
        tests++;
        if (lat !== 2) begin failed++; $display("FAIL test_latency got %0d want 2", lat); end
        tests++;
        if (d_load !== 1 || d_store !== 0) begin
            failed++;
            $display("FAIL test_strobes got load=%0d store=%0d want 1/0", d_load, d_store);
        end
        tests++;
        if (z_done !== 1'b1) begin failed++; $display("FAIL test_zero got %b want 1", z_done); end
        @(posedge CLOCK);
        #1;
        tests++;
        if ({ZERO, DONE} !== 2'b10) begin
            failed++;
            $display("FAIL zero_hold got %b want 10", {ZERO, DONE});
        end
        cell_m = 8'h2A;
        issue(OP_TEST, 12'd0);
        tests++;
        if (z_done !== 1'b0 || lat !== 2) begin
            failed++;
            $display("FAIL test_nonzero got zero=%b lat=%0d want 0/2", z_done, lat);
        end
    endtask

    task automatic test_dec_wrap();
        cell_m = 8'h00;
        issue(OP_DEC, 12'd2);
        tests++;
        if (lat !== 5) begin failed++; $display("FAIL wrap_latency got %0d want 5", lat); end
        tests++;
        if (d_inc !== 0 || d_dec !== 2) begin
            failed++;
            $display("FAIL wrap_pulses got inc=%0d dec=%0d want 0/2", d_inc, d_dec);
        end
        tests++;
        if (cell_m !== 8'hFE) begin failed++; $display("FAIL wrap_cell got %h want fe", cell_m); end
        tests++;
        if (z_done !== 1'b0) begin failed++; $display("FAIL wrap_zero got %b want 0", z_done); end
    endtask

    task automatic test_clear();
        cell_m = 8'h03;
        issue(OP_CLR, 12'd5);
        tests++;
        if (lat !== 6) begin failed++; $display("FAIL clr3_latency got %0d want 6", lat); end
        tests++;
        if (d_dec !== 3 || d_inc !== 0) begin
            failed++;
            $display("FAIL clr3_pulses got dec=%0d inc=%0d want 3/0", d_dec, d_inc);
        end
        tests++;
        if (d_store !== 1 || z_done !== 1'b1 || cell_m !== 8'h00) begin
            failed++;
            $display("FAIL clr3_result got store=%0d zero=%b cell=%h want 1/1/00",
                     d_store, z_done, cell_m);
        end
        issue(OP_CLR, 12'd0);
        tests++;
        if (lat !== 3) begin failed++; $display("FAIL clr0_latency got %0d want 3", lat); end
        tests++;
        if (d_dec !== 0 || d_load !== 1 || d_store !== 1 || z_done !== 1'b1) begin
            failed++;
            $display("FAIL clr0_result got dec=%0d load=%0d store=%0d zero=%b want 0/1/1/1",
                     d_dec, d_load, d_store, z_done);
        end
    endtask

    task automatic test_fold();
        cell_m = 8'h07;
        issue(OP_INC, 12'd256);
`ifdef DL_SEQ_FOLD_EN
        tests++;
        if (lat !== 2) begin failed++; $display("FAIL n256_latency got %0d want 2", lat); end
        tests++;
        if (d_inc !== 0 || d_store !== 0) begin
            failed++;
            $display("FAIL n256_strobes got inc=%0d store=%0d want 0/0", d_inc, d_store);
        end
`else
        tests++;
        if (lat !== 259) begin failed++; $display("FAIL n256_latency got %0d want 259", lat); end
        tests++;
        if (d_inc !== 256 || d_store !== 1) begin
            failed++;
            $display("FAIL n256_strobes got inc=%0d store=%0d want 256/1", d_inc, d_store);
        end
`endif
        tests++;
        if (z_done !== 1'b0 || cell_m !== 8'h07) begin
            failed++;
            $display("FAIL n256_result got zero=%b cell=%h want 0/07", z_done, cell_m);
        end
        cell_m = 8'h00;
        issue(OP_INC, 12'd0);
`ifdef DL_SEQ_FOLD_EN
        tests++;
        if (lat !== 2 || d_store !== 0) begin
            failed++;
            $display("FAIL n0_seq got lat=%0d store=%0d want 2/0", lat, d_store);
        end
`else
        tests++;
        if (lat !== 3 || d_store !== 1) begin
            failed++;
            $display("FAIL n0_seq got lat=%0d store=%0d want 3/1", lat, d_store);
        end
`endif
        tests++;
        if (z_done !== 1'b1 || d_inc !== 0) begin
            failed++;
            $display("FAIL n0_result got zero=%b inc=%0d want 1/0", z_done, d_inc);
        end
        cell_m = 8'hFE;
        issue(OP_INC, 12'h105);
`ifdef DL_SEQ_FOLD_EN
        tests++;
        if (lat !== 8 || d_inc !== 5) begin
            failed++;
            $display("FAIL n261_seq got lat=%0d inc=%0d want 8/5", lat, d_inc);
        end
`else
        tests++;
        if (lat !== 264 || d_inc !== 261) begin
            failed++;
            $display("FAIL n261_seq got lat=%0d inc=%0d want 264/261", lat, d_inc);
        end
`endif
        tests++;
        if (cell_m !== 8'h03 || z_done !== 1'b0) begin
            failed++;
            $display("FAIL n261_result got cell=%h zero=%b want 03/0", cell_m, z_done);
        end
    endtask

    task automatic test_reset_mid();
        int s_store;
        cell_m = 8'h20;
        @(posedge CLOCK);
        #1;
        s_store = n_store;
        CMD_OP = OP_INC;
        CMD_COUNT = 12'd10;
        CMD_VALID = 1'b1;
        @(posedge CLOCK);
        #1;
        CMD_VALID = 1'b0;
        repeat (4) begin
            @(posedge CLOCK);
            #1;
        end
        tests++;
        if ({BUSY, INC} !== 2'b11) begin
            failed++;
            $display("FAIL mid_in_step got %b want 11", {BUSY, INC});
        end
        #2;
        RST = 1'b0;
        #1;
        tests++;
        if ({CMD_READY, BUSY, LOAD, INC, DEC, STORE, DONE, ZERO} !== 8'b1000_0000) begin
            failed++;
            $display("FAIL mid_async got %b want %b",
                     {CMD_READY, BUSY, LOAD, INC, DEC, STORE, DONE, ZERO}, 8'b1000_0000);
        end
        repeat (2) @(negedge CLOCK);
        RST = 1'b1;
        @(posedge CLOCK);
        #1;
        tests++;
        if (n_store - s_store !== 0 || cell_m !== 8'h20) begin
            failed++;
            $display("FAIL mid_no_store got store=%0d cell=%h want 0/20",
                     n_store - s_store, cell_m);
        end
        issue(OP_DEC, 12'd1);
        tests++;
        if (lat !== 4 || cell_m !== 8'h1F) begin
            failed++;
            $display("FAIL mid_recover got lat=%0d cell=%h want 4/1f", lat, cell_m);
        end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_back_to_back();
        test_dec_and_test();
        test_dec_wrap();
        test_clear();
        test_fold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
